bus_cycle_initiator: RTL

// - Initiator end of the 8088-style memory/IO bus. Converts a single-beat host request (REQ/ACK)

---
 rtl/bus_cycle_initiator.sv | 131 +++++++++++++
 1 files changed

// File: rtl/bus_cycle_initiator.sv
// 8088-style bus initiator: turns one host request into a T1-T4 bus cycle with READY wait states.
// Optional TW watchdog enabled by defining BUS_TIMEOUT_EN (aborts with ERR=1 after TIMEOUT_CYCLES).
module bus_cycle_initiator #(
  parameter int ADDR_WIDTH     = 20,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  REQ,
  input  logic                  REQ_WR,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ_WDATA,
  output logic                  ACK,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic                  ERR,
  output logic                  BUSY,
  output logic [ADDR_WIDTH-1:0] ADDRESS,
  output logic                  ALE,
  output logic                  RD,
  output logic                  WR,
  input  logic                  READY,
  inout  wire  [DATA_WIDTH-1:0] DATA
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_T1   = 3'd1;
  localparam logic [2:0] S_T2   = 3'd2;
  localparam logic [2:0] S_T3   = 3'd3;
  localparam logic [2:0] S_TW   = 3'd4;
  localparam logic [2:0] S_T4   = 3'd5;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef struct packed {
    logic                  wr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  logic [2:0] state, state_d;
  req_t       req_q;
  logic       data_oe;
  logic       tmo_hit;

  assign DATA = data_oe ? req_q.wdata : {DATA_WIDTH{1'bz}};

`ifdef BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tw_cnt;

  // tw_cnt holds the number of TW cycles already spent, so the abort fires in the last allowed TW
  assign tmo_hit = (state == S_TW) && !READY && (tw_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)                      tw_cnt <= '0;
    else if (state == S_T2)            tw_cnt <= '0;
    else if (state == S_TW && !READY)  tw_cnt <= tw_cnt + CW'(1);
  end
`else
  assign tmo_hit = 1'b0;
  assign ERR     = 1'b0;
`endif

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:     if (REQ) state_d = S_T1;
      S_T1:       state_d = S_T2;
      S_T2:       state_d = S_T3;
      S_T3, S_TW: state_d = (READY || tmo_hit) ? S_T4 : S_TW;
      S_T4:       state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= S_IDLE;
      req_q   <= '0;
      data_oe <= 1'b0;
      ADDRESS <= '0;
      ALE     <= 1'b0;
      RD      <= 1'b1;
      WR      <= 1'b1;
      ACK     <= 1'b0;
      BUSY    <= 1'b0;
      RDATA   <= '0;
`ifdef BUS_TIMEOUT_EN
      ERR     <= 1'b0;
`endif
    end else begin
      state <= state_d;
      BUSY  <= (state_d != S_IDLE);
      ACK   <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      ERR   <= 1'b0;
`endif
      case (state)
        S_IDLE: if (REQ) begin
          req_q   <= '{wr: REQ_WR, wdata: REQ_WDATA};
          ADDRESS <= REQ_ADDR;
          ALE     <= 1'b1;
        end
        S_T1: begin
          ALE <= 1'b0;
          if (req_q.wr) begin
            WR      <= 1'b0;
            data_oe <= 1'b1;
          end else begin
            RD <= 1'b0;
          end
        end
        S_T3, S_TW: if (state_d == S_T4) begin
          RD  <= 1'b1;
          WR  <= 1'b1;
          ACK <= 1'b1;
          if (!req_q.wr) RDATA <= tmo_hit ? {DATA_WIDTH{1'b1}} : DATA;
`ifdef BUS_TIMEOUT_EN
          ERR <= tmo_hit;
`endif
        end
        // write data is held through T4 and released as the cycle ends
        S_T4: data_oe <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
